turn_signal_decoder: RTL and testbench



---
 rtl/turn_signal_pkg.sv | 39 +++
 rtl/turn_signal_classifier.sv | 42 ++++
 rtl/turn_signal_decoder.sv | 189 ++++++++++++++++++
 tb/tb_turn_signal_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_signal_pkg.sv
// Shared lamp patterns, input classes and decoder states
// for the turn-signal lamp monitor.
package turn_signal_pkg;

  localparam int HOLD_DEF = 3;

  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_L1  = 3'b001;
  localparam logic [2:0] PAT_L2  = 3'b011;
  localparam logic [2:0] PAT_L3  = 3'b111;
  localparam logic [2:0] PAT_R1  = 3'b100;
  localparam logic [2:0] PAT_R2  = 3'b110;
  localparam logic [2:0] PAT_R3  = 3'b111;

  typedef enum logic [3:0] {
    C_IDLE,
    C_ERR,
    C_L1,
    C_L2,
    C_L3,
    C_R1,
    C_R2,
    C_R3,
    C_ILLEGAL
  } lamp_class_t;

  typedef enum logic [3:0] {
    D_IDLE,
    D_ERR,
    D_L1,
    D_L2,
    D_L3,
    D_R1,
    D_R2,
    D_R3,
    D_BAD
  } dec_state_t;

endpackage

// File: rtl/turn_signal_classifier.sv
// Combinational lamp-pattern classifier: maps the
// two lamp buses and the error flag to one class.
module turn_signal_classifier
  import turn_signal_pkg::*;
(
  input  logic [2:0]  l_signal,
  input  logic [2:0]  r_signal,
  input  logic        error_n,
  output lamp_class_t lamp_class
);

  logic l_off;
  logic r_off;

  assign l_off = (l_signal == PAT_OFF);
  assign r_off = (r_signal == PAT_OFF);

  always_comb begin
    lamp_class = C_ILLEGAL;
    unique case (1'b1)
      l_off && r_off && error_n:
        lamp_class = C_IDLE;
      l_off && r_off && !error_n:
        lamp_class = C_ERR;
      r_off && error_n && l_signal == PAT_L1:
        lamp_class = C_L1;
      r_off && error_n && l_signal == PAT_L2:
        lamp_class = C_L2;
      r_off && error_n && l_signal == PAT_L3:
        lamp_class = C_L3;
      l_off && error_n && r_signal == PAT_R1:
        lamp_class = C_R1;
      l_off && error_n && r_signal == PAT_R2:
        lamp_class = C_R2;
      l_off && error_n && r_signal == PAT_R3:
        lamp_class = C_R3;
      default:
        lamp_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/turn_signal_decoder.sv
// Lamp-side sweep decoder and protocol checker for
// the turn-signal machine; all outputs registered.
module turn_signal_decoder
  import turn_signal_pkg::*;
#(
  parameter int HOLD  = HOLD_DEF,
  parameter int CNT_W = 8
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [2:0]       L_SIGNAL,
  input  logic [2:0]       R_SIGNAL,
  input  logic             ERROR,
  output logic             LEFT_ACTIVE,
  output logic             RIGHT_ACTIVE,
  output logic [1:0]       STAGE,
  output logic             FAULT,
  output logic             SEQ_ERROR,
  output logic             SWEEP_DONE,
  output logic [CNT_W-1:0] VIOL_COUNT
);

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] HOLD_R = RUN_W'(HOLD);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HOLD + 1);

  lamp_class_t      cls;
  lamp_class_t      prev_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  dec_state_t       state_q;
  dec_state_t       state_d;

  lamp_class_t same;
  lamp_class_t up;
  dec_state_t  up_st;
  logic        lamp;
  logic        is3;
  logic        hold_ok;
  logic        hold_short;
  logic        viol;
  logic        done;

  logic       left_d;
  logic       right_d;
  logic [1:0] stage_d;

  turn_signal_classifier u_cls (
    .l_signal   (L_SIGNAL),
    .r_signal   (R_SIGNAL),
    .error_n    (ERROR),
    .lamp_class (cls)
  );

  // run_q == 0 only straight after reset: first sample starts a run
  always_comb begin
    run_d = RUN_W'(1);
    if (run_q != '0 && cls == prev_q) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end
  end

  assign hold_ok    = (run_q == HOLD_R);
  assign hold_short = (run_q < HOLD_R);

  always_comb begin
    same  = C_ILLEGAL;
    up    = C_ILLEGAL;
    up_st = D_BAD;
    lamp  = 1'b0;
    is3   = 1'b0;
    unique case (state_q)
      D_L1: begin
        same = C_L1; up = C_L2; up_st = D_L2; lamp = 1'b1;
      end
      D_L2: begin
        same = C_L2; up = C_L3; up_st = D_L3; lamp = 1'b1;
      end
      D_L3: begin
        same = C_L3; lamp = 1'b1; is3 = 1'b1;
      end
      D_R1: begin
        same = C_R1; up = C_R2; up_st = D_R2; lamp = 1'b1;
      end
      D_R2: begin
        same = C_R2; up = C_R3; up_st = D_R3; lamp = 1'b1;
      end
      D_R3: begin
        same = C_R3; lamp = 1'b1; is3 = 1'b1;
      end
      default: begin
        lamp = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    viol    = 1'b0;
    done    = 1'b0;
    if (lamp) begin
      if (cls == same && hold_short) begin
        state_d = state_q;
      end else if (hold_ok && !is3 && cls == up) begin
        state_d = up_st;
      end else if (hold_ok && cls == C_IDLE) begin
        state_d = D_IDLE;
        done    = is3;
      end else if (hold_ok && cls == C_ERR) begin
        state_d = D_ERR;
        done    = is3;
      end else begin
        viol = 1'b1;
      end
    end else begin
      unique case (state_q)
        D_IDLE: begin
          unique case (cls)
            C_IDLE:  state_d = D_IDLE;
            C_ERR:   state_d = D_ERR;
            C_L1:    state_d = D_L1;
            C_R1:    state_d = D_R1;
            default: viol = 1'b1;
          endcase
        end
        D_ERR: begin
          unique case (cls)
            C_ERR:   state_d = D_ERR;
            C_IDLE:  state_d = D_IDLE;
            default: viol = 1'b1;
          endcase
        end
        default: begin
          if (cls == C_IDLE) state_d = D_IDLE;
          else if (cls == C_ERR) state_d = D_ERR;
          else state_d = D_BAD;
        end
      endcase
    end
    if (viol) begin
      state_d = D_BAD;
      done    = 1'b0;
    end
  end

  always_comb begin
    left_d  = 1'b0;
    right_d = 1'b0;
    stage_d = 2'd0;
    unique case (state_d)
      D_L1: begin left_d = 1'b1; stage_d = 2'd1; end
      D_L2: begin left_d = 1'b1; stage_d = 2'd2; end
      D_L3: begin left_d = 1'b1; stage_d = 2'd3; end
      D_R1: begin right_d = 1'b1; stage_d = 2'd1; end
      D_R2: begin right_d = 1'b1; stage_d = 2'd2; end
      D_R3: begin right_d = 1'b1; stage_d = 2'd3; end
      default: stage_d = 2'd0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= D_IDLE;
      prev_q       <= C_IDLE;
      run_q        <= '0;
      LEFT_ACTIVE  <= 1'b0;
      RIGHT_ACTIVE <= 1'b0;
      STAGE        <= 2'd0;
      FAULT        <= 1'b0;
      SEQ_ERROR    <= 1'b0;
      SWEEP_DONE   <= 1'b0;
      VIOL_COUNT   <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= cls;
      run_q        <= run_d;
      LEFT_ACTIVE  <= left_d;
      RIGHT_ACTIVE <= right_d;
      STAGE        <= stage_d;
      FAULT        <= (state_d == D_ERR);
      SEQ_ERROR    <= viol;
      SWEEP_DONE   <= done;
      if (viol && VIOL_COUNT != '1) begin
        VIOL_COUNT <= VIOL_COUNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_turn_signal_decoder.sv
// Directed bench for turn_signal_decoder: sweeps,
// protocol violations, error path, reset, saturation.
module tb_turn_signal_decoder;

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic [2:0] L_SIGNAL;
  logic [2:0] R_SIGNAL;
  logic       ERROR;

  logic       LEFT_ACTIVE, RIGHT_ACTIVE;
  logic [1:0] STAGE;
  logic       FAULT, SEQ_ERROR, SWEEP_DONE;
  logic [7:0] VIOL_COUNT;

  logic       s_left, s_right;
  logic [1:0] s_stage;
  logic       s_fault, s_seq, s_done;
  logic [1:0] s_count;

  int checks = 0;
  int fails  = 0;

  always #5 CLOCK = ~CLOCK;

  turn_signal_decoder #(.HOLD(3), .CNT_W(8)) dut (
    .CLOCK        (CLOCK),
    .RESET_N      (RESET_N),
    .L_SIGNAL     (L_SIGNAL),
    .R_SIGNAL     (R_SIGNAL),
    .ERROR        (ERROR),
    .LEFT_ACTIVE  (LEFT_ACTIVE),
    .RIGHT_ACTIVE (RIGHT_ACTIVE),
    .STAGE        (STAGE),
    .FAULT        (FAULT),
    .SEQ_ERROR    (SEQ_ERROR),
    .SWEEP_DONE   (SWEEP_DONE),
    .VIOL_COUNT   (VIOL_COUNT)
  );

  turn_signal_decoder #(.HOLD(3), .CNT_W(2)) dut_sat (
    .CLOCK        (CLOCK),
    .RESET_N      (RESET_N),
    .L_SIGNAL     (L_SIGNAL),
    .R_SIGNAL     (R_SIGNAL),
    .ERROR        (ERROR),
    .LEFT_ACTIVE  (s_left),
    .RIGHT_ACTIVE (s_right),
    .STAGE        (s_stage),
    .FAULT        (s_fault),
    .SEQ_ERROR    (s_seq),
    .SWEEP_DONE   (s_done),
    .VIOL_COUNT   (s_count)
  );

  // vector = {L, R, ERROR, left, right, stage, fault, seq, done}
  task automatic test_reset;
    RESET_N  = 1'b0;
    L_SIGNAL = 3'b000;
    R_SIGNAL = 3'b000;
    ERROR    = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1;
    checks++;
    if ({LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
         SWEEP_DONE, VIOL_COUNT} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0",
        {LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
         SWEEP_DONE, VIOL_COUNT});
    end
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  task automatic test_full_sweep;
    logic [13:0] v [13] = '{
      {3'b000, 3'b000, 1'b1, 7'b0000000},
      {3'b000, 3'b000, 1'b1, 7'b0000000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b011, 3'b000, 1'b1, 7'b1010000},
      {3'b011, 3'b000, 1'b1, 7'b1010000},
      {3'b011, 3'b000, 1'b1, 7'b1010000},
      {3'b111, 3'b000, 1'b1, 7'b1011000},
      {3'b111, 3'b000, 1'b1, 7'b1011000},
      {3'b111, 3'b000, 1'b1, 7'b1011000},
      {3'b000, 3'b000, 1'b1, 7'b0000001},
      {3'b000, 3'b000, 1'b1, 7'b0000000}
    };
    foreach (v[i]) begin
      L_SIGNAL = v[i][13:11];
      R_SIGNAL = v[i][10:8];
      ERROR    = v[i][7];
      @(posedge CLOCK); #1;
      checks++;
      if ({LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
           SWEEP_DONE} !== v[i][6:0]) begin
        fails++;
        $display("FAIL sweep_v%0d: got %b expected %b", i,
          {LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
           SWEEP_DONE}, v[i][6:0]);
      end
    end
    checks++;
    if (VIOL_COUNT !== 8'd0) begin
      fails++;
      $display("FAIL sweep_count: got %0d expected 0", VIOL_COUNT);
    end
  endtask

  task automatic test_early_release;
    logic [13:0] v [7] = '{
      {3'b000, 3'b100, 1'b1, 7'b0101000},
      {3'b000, 3'b100, 1'b1, 7'b0101000},
      {3'b000, 3'b100, 1'b1, 7'b0101000},
      {3'b000, 3'b110, 1'b1, 7'b0110000},
      {3'b000, 3'b110, 1'b1, 7'b0110000},
      {3'b000, 3'b110, 1'b1, 7'b0110000},
      {3'b000, 3'b000, 1'b1, 7'b0000000}
    };
    foreach (v[i]) begin
      L_SIGNAL = v[i][13:11];
      R_SIGNAL = v[i][10:8];
      ERROR    = v[i][7];
      @(posedge CLOCK); #1;
      checks++;
      if ({LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
           SWEEP_DONE} !== v[i][6:0]) begin
        fails++;
        $display("FAIL early_v%0d: got %b expected %b", i,
          {LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
           SWEEP_DONE}, v[i][6:0]);
      end
    end
  endtask

  task automatic test_short_hold;
    logic [13:0] v [9] = '{
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b011, 3'b000, 1'b1, 7'b0000010},
      {3'b011, 3'b000, 1'b1, 7'b0000000},
      {3'b000, 3'b000, 1'b1, 7'b0000000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b000, 3'b000, 1'b1, 7'b0000000}
    };
    foreach (v[i]) begin
      L_SIGNAL = v[i][13:11];
      R_SIGNAL = v[i][10:8];
      ERROR    = v[i][7];
      @(posedge CLOCK); #1;
      checks++;
      if ({LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
           SWEEP_DONE} !== v[i][6:0]) begin
        fails++;
        $display("FAIL short_v%0d: got %b expected %b", i,
          {LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
           SWEEP_DONE}, v[i][6:0]);
      end
    end
    checks++;
    if (VIOL_COUNT !== 8'd1) begin
      fails++;
      $display("FAIL short_count: got %0d expected 1", VIOL_COUNT);
    end
  endtask

  task automatic test_skip_and_long;
    logic [13:0] v [14] = '{
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b111, 3'b000, 1'b1, 7'b0000010},
      {3'b000, 3'b000, 1'b1, 7'b0000000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b011, 3'b000, 1'b1, 7'b1010000},
      {3'b011, 3'b000, 1'b1, 7'b1010000},
      {3'b011, 3'b000, 1'b1, 7'b1010000},
      {3'b011, 3'b000, 1'b1, 7'b0000010},
      {3'b000, 3'b000, 1'b1, 7'b0000000},
      {3'b000, 3'b000, 1'b1, 7'b0000000}
    };
    foreach (v[i]) begin
      L_SIGNAL = v[i][13:11];
      R_SIGNAL = v[i][10:8];
      ERROR    = v[i][7];
      @(posedge CLOCK); #1;
      checks++;
      if ({LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
           SWEEP_DONE} !== v[i][6:0]) begin
        fails++;
        $display("FAIL skip_v%0d: got %b expected %b", i,
          {LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
           SWEEP_DONE}, v[i][6:0]);
      end
    end
    checks++;
    if (VIOL_COUNT !== 8'd3) begin
      fails++;
      $display("FAIL skip_count: got %0d expected 3", VIOL_COUNT);
    end
  endtask

  task automatic test_error_path;
    logic [13:0] v [11] = '{
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b001, 3'b000, 1'b1, 7'b1001000},
      {3'b000, 3'b000, 1'b0, 7'b0000100},
      {3'b000, 3'b000, 1'b0, 7'b0000100},
      {3'b000, 3'b000, 1'b0, 7'b0000100},
      {3'b000, 3'b000, 1'b0, 7'b0000100},
      {3'b000, 3'b000, 1'b0, 7'b0000100},
      {3'b000, 3'b000, 1'b1, 7'b0000000},
      {3'b001, 3'b100, 1'b1, 7'b0000010},
      {3'b000, 3'b000, 1'b1, 7'b0000000}
    };
    foreach (v[i]) begin
      L_SIGNAL = v[i][13:11];
      R_SIGNAL = v[i][10:8];
      ERROR    = v[i][7];
      @(posedge CLOCK); #1;
      checks++;
      if ({LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
           SWEEP_DONE} !== v[i][6:0]) begin
        fails++;
        $display("FAIL err_v%0d: got %b expected %b", i,
          {LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
           SWEEP_DONE}, v[i][6:0]);
      end
    end
    checks++;
    if (VIOL_COUNT !== 8'd4) begin
      fails++;
      $display("FAIL err_count: got %0d expected 4", VIOL_COUNT);
    end
  endtask

  task automatic test_reset_and_saturate;
    logic [2:0] pre_l [4] = '{3'b001, 3'b001, 3'b001, 3'b011};
    logic [1:0] exp_sat;
    foreach (pre_l[i]) begin
      L_SIGNAL = pre_l[i];
      R_SIGNAL = 3'b000;
      ERROR    = 1'b1;
      @(posedge CLOCK); #1;
    end
    checks++;
    if (STAGE !== 2'd2 || LEFT_ACTIVE !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_stage: got %0d/%b expected 2/1",
        STAGE, LEFT_ACTIVE);
    end
    #1;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
         SWEEP_DONE, VIOL_COUNT, s_count} !== 17'd0) begin
      fails++;
      $display("FAIL async_reset: got %b expected 0",
        {LEFT_ACTIVE, RIGHT_ACTIVE, STAGE, FAULT, SEQ_ERROR,
         SWEEP_DONE, VIOL_COUNT, s_count});
    end
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(posedge CLOCK); #1;
    checks++;
    if ({LEFT_ACTIVE, STAGE, SEQ_ERROR, VIOL_COUNT} !== {4'b0001, 8'd1})
    begin
      fails++;
      $display("FAIL resume_viol: got %b/%0d expected 0001/1",
        {LEFT_ACTIVE, STAGE, SEQ_ERROR}, VIOL_COUNT);
    end
    for (int k = 2; k <= 5; k++) begin
      L_SIGNAL = 3'b000;
      R_SIGNAL = 3'b000;
      @(posedge CLOCK); #1;
      L_SIGNAL = 3'b001;
      R_SIGNAL = 3'b100;
      @(posedge CLOCK); #1;
      exp_sat = (k >= 3) ? 2'd3 : 2'(k);
      checks++;
      if (s_count !== exp_sat || s_seq !== 1'b1) begin
        fails++;
        $display("FAIL sat_v%0d: got cnt=%0d seq=%b expected %0d/1",
          k, s_count, s_seq, exp_sat);
      end
    end
    checks++;
    if (VIOL_COUNT !== 8'd5) begin
      fails++;
      $display("FAIL wide_count: got %0d expected 5", VIOL_COUNT);
    end
    L_SIGNAL = 3'b000;
    R_SIGNAL = 3'b000;
    @(posedge CLOCK); #1;
    checks++;
    if (s_count !== 2'd3 || s_seq !== 1'b0) begin
      fails++;
      $display("FAIL sat_hold: got cnt=%0d seq=%b expected 3/0",
        s_count, s_seq);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_early_release();
    test_short_hold();
    test_skip_and_long();
    test_error_path();
    test_reset_and_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule
